// File: rtl/pace_scheduler.sv
// rtl/pace_scheduler.sv - variable-period game tick generator with pause and blink
//
// Purpose: emits a one-cycle tick every `period` clk cycles while running.
// The period starts at BASE_PERIOD, shrinks by STEP per speed level down to
// MIN_PERIOD, and can be reset to level 0. A blink square wave toggles
// every BLINK_TICKS ticks.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   level; low forces IDLE
//   pause_toggle  in   one-cycle pulse; toggles RUN/PAUSED
//   speed_up      in   one-cycle pulse; request next speed level
//   speed_reset   in   one-cycle pulse; return to level 0
//   tick          out  registered one-cycle pace pulse
//   level         out  current speed level
//   paused        out  high while PAUSED
//   blink         out  square wave, toggles every BLINK_TICKS ticks
module pace_scheduler #(
  parameter int BASE_PERIOD = 6250000,
  parameter int STEP        = 390625,
  parameter int MIN_PERIOD  = 1562500,
  parameter int CNT_W       = 23,
  parameter int LEVEL_W     = 4,
  parameter int BLINK_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pause_toggle,
  input  logic               speed_up,
  input  logic               speed_reset,
  output logic               tick,
  output logic [LEVEL_W-1:0] level,
  output logic               paused,
  output logic               blink
);

  localparam int TCNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TCNT_W-1:0] LP_TCNT_LAST   = TCNT_W'(BLINK_TICKS - 1);
  localparam logic [CNT_W-1:0]  LP_BASE        = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0]  LP_STEP        = CNT_W'(STEP);
  // Compare against floor+step instead of subtracting first, so a small
  // period can never underflow into a huge one.
  localparam logic [CNT_W-1:0]  LP_SPEED_FLOOR = CNT_W'(MIN_PERIOD + STEP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_period;
  logic [LEVEL_W-1:0]  r_level;
  logic [TCNT_W-1:0]   r_tick_cnt;
  logic                r_tick;
  logic                r_paused;
  logic                r_blink;

  logic                w_wrap;
  logic                w_can_speed;

  // ">=" rather than "==" so a period that just shrank below the current
  // count still produces exactly one tick on the next RUN edge.
  assign w_wrap      = (r_count >= (r_period - CNT_W'(1)));
  assign w_can_speed = (r_period >= LP_SPEED_FLOOR) && (r_level != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_period   <= LP_BASE;
      r_level    <= '0;
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
      r_paused   <= 1'b0;
      r_blink    <= 1'b0;
    end else begin
      // Speed control runs in every state; reset dominates a same-cycle request.
      if (speed_reset) begin
        r_period <= LP_BASE;
        r_level  <= '0;
      end else if (speed_up && w_can_speed) begin
        r_period <= r_period - LP_STEP;
        r_level  <= r_level + LEVEL_W'(1);
      end

      if (!enable) begin
        // Level, period and blink survive a disable.
        r_state    <= ST_IDLE;
        r_count    <= '0;
        r_tick_cnt <= '0;
        r_tick     <= 1'b0;
        r_paused   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_count    <= '0;
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            r_state    <= ST_RUN;
          end
          ST_RUN: begin
            if (pause_toggle) begin
              // Pause beats a coinciding wrap: count stays put, so the
              // pending tick fires on the first edge after resume.
              r_state  <= ST_PAUSED;
              r_paused <= 1'b1;
              r_tick   <= 1'b0;
            end else if (w_wrap) begin
              r_count <= '0;
              r_tick  <= 1'b1;
              if (r_tick_cnt == LP_TCNT_LAST) begin
                r_tick_cnt <= '0;
                r_blink    <= ~r_blink;
              end else begin
                r_tick_cnt <= r_tick_cnt + TCNT_W'(1);
              end
            end else begin
              r_count <= r_count + CNT_W'(1);
              r_tick  <= 1'b0;
            end
          end
          ST_PAUSED: begin
            r_tick <= 1'b0;
            if (pause_toggle) begin
              r_state  <= ST_RUN;
              r_paused <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tick  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tick   = r_tick;
  assign level  = r_level;
  assign paused = r_paused;
  assign blink  = r_blink;

endmodule

// File: tb/tb_pace_scheduler.sv
// tb/tb_pace_scheduler.sv - scoreboard bench for pace_scheduler
module tb_pace_scheduler;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       pause_toggle;
  logic       speed_up;
  logic       speed_reset;
  logic       tick;
  logic [3:0] level;
  logic       paused;
  logic       blink;

  pace_scheduler #(
    .BASE_PERIOD(20),
    .STEP(4),
    .MIN_PERIOD(8),
    .CNT_W(6),
    .LEVEL_W(4),
    .BLINK_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .pause_toggle(pause_toggle),
    .speed_up(speed_up),
    .speed_reset(speed_reset),
    .tick(tick),
    .level(level),
    .paused(paused),
    .blink(blink)
  );

  typedef struct {
    int   cyc;
    logic blink;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_tcnt = 0;
  logic exp_blink = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected tick at a given edge; blink follows a toggle every 2nd tick.
  task automatic push_tick(input int e);
    exp_t x;
    exp_tcnt++;
    if (exp_tcnt == 2) begin
      exp_tcnt  = 0;
      exp_blink = ~exp_blink;
    end
    x.cyc   = e;
    x.blink = exp_blink;
    q.push_back(x);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // At each negedge, cyc is the number of the edge that set the outputs.
  always @(negedge clk) begin
    if (q.size() > 0 && cyc > q[0].cyc) begin
      m_e = q.pop_front();
      check("tick_miss", cyc, m_e.cyc);
    end
    if (tick) begin
      if (q.size() == 0) begin
        check("tick_unexp", tick, 1'b0);
      end else begin
        m_e = q.pop_front();
        check("tick_cyc", cyc, m_e.cyc);
        check("tick_blink", blink, m_e.blink);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, l1, l2, t, l4, l5, l6, tr;
    rst_n        = 1'b0;
    enable       = 1'b0;
    pause_toggle = 1'b0;
    speed_up     = 1'b0;
    speed_reset  = 1'b0;

    wait_edge(3);
    check("rst_tick", tick, 1'b0);
    check("rst_level", level, 4'd0);
    check("rst_paused", paused, 1'b0);
    check("rst_blink", blink, 1'b0);
    rst_n = 1'b1;

    // Base period 20: ticks at RUN edges 20, 40, 60, 80.
    wait_edge(5);
    enable = 1'b1;
    t0 = cyc;
    push_tick(t0 + 21);
    push_tick(t0 + 41);
    push_tick(t0 + 61);
    push_tick(t0 + 81);
    wait_edge(t0 + 30);
    check("lvl0", level, 4'd0);
    check("run_paused", paused, 1'b0);

    // Pause at count 10, hold 50 cycles, resume.
    l1 = t0 + 81;
    wait_edge(l1 + 10);
    pause_toggle = 1'b1;
    wait_edge(l1 + 11);
    pause_toggle = 1'b0;
    check("pause_on", paused, 1'b1);
    wait_edge(l1 + 35);
    check("pause_hold", paused, 1'b1);
    check("pause_blink", blink, exp_blink);
    wait_edge(l1 + 60);
    pause_toggle = 1'b1;
    wait_edge(l1 + 61);
    pause_toggle = 1'b0;
    check("pause_off", paused, 1'b0);
    push_tick(l1 + 71);

    // Pause coinciding with the wrap compare: no tick, then tick right after resume.
    l2 = l1 + 71;
    wait_edge(l2 + 19);
    pause_toggle = 1'b1;
    wait_edge(l2 + 20);
    pause_toggle = 1'b0;
    check("tie_paused", paused, 1'b1);
    wait_edge(l2 + 24);
    pause_toggle = 1'b1;
    wait_edge(l2 + 25);
    pause_toggle = 1'b0;
    push_tick(l2 + 26);

    // Four speed-ups, one per period: 16, 12, 8, then saturate at 8.
    t = l2 + 26;
    wait_edge(t);
    speed_up = 1'b1;
    wait_edge(t + 1);
    speed_up = 1'b0;
    check("lvl1", level, 4'd1);
    push_tick(t + 16);
    wait_edge(t + 16);
    speed_up = 1'b1;
    wait_edge(t + 17);
    speed_up = 1'b0;
    check("lvl2", level, 4'd2);
    push_tick(t + 28);
    wait_edge(t + 28);
    speed_up = 1'b1;
    wait_edge(t + 29);
    speed_up = 1'b0;
    check("lvl3", level, 4'd3);
    push_tick(t + 36);
    wait_edge(t + 36);
    speed_up = 1'b1;
    wait_edge(t + 37);
    speed_up = 1'b0;
    check("lvl_sat", level, 4'd3);
    push_tick(t + 44);

    // Level 3, count 5: speed_reset and speed_up together -> level 0, period 20.
    l4 = t + 44;
    wait_edge(l4 + 5);
    speed_up    = 1'b1;
    speed_reset = 1'b1;
    wait_edge(l4 + 6);
    speed_up    = 1'b0;
    speed_reset = 1'b0;
    check("lvl_rst_wins", level, 4'd0);
    push_tick(l4 + 20);

    // Level 0, count reaches 15 as period drops to 12 -> immediate tick, then 12.
    l5 = l4 + 20;
    wait_edge(l5 + 13);
    speed_up = 1'b1;
    wait_edge(l5 + 15);
    speed_up = 1'b0;
    check("lvl_two_ups", level, 4'd2);
    push_tick(l5 + 16);
    push_tick(l5 + 28);
    push_tick(l5 + 40);

    // Disable mid-period: IDLE, level and blink retained, tick_cnt cleared.
    l6 = l5 + 40;
    wait_edge(l6 + 5);
    enable = 1'b0;
    wait_edge(l6 + 6);
    exp_tcnt = 0;
    check("dis_paused", paused, 1'b0);
    check("dis_tick", tick, 1'b0);
    check("dis_level", level, 4'd2);
    check("dis_blink", blink, exp_blink);
    wait_edge(l6 + 8);
    enable = 1'b1;
    push_tick(l6 + 21);
    wait_edge(l6 + 24);
    pause_toggle = 1'b1;
    wait_edge(l6 + 25);
    pause_toggle = 1'b0;
    check("pre_rst_paused", paused, 1'b1);

    // Asynchronous reset between clock edges while PAUSED.
    wait_edge(l6 + 30);
    #2;
    rst_n = 1'b0;
    #1;
    exp_tcnt  = 0;
    exp_blink = 1'b0;
    check("arst_tick", tick, 1'b0);
    check("arst_paused", paused, 1'b0);
    check("arst_level", level, 4'd0);
    check("arst_blink", blink, 1'b0);
    wait_edge(l6 + 33);
    check("arst_hold_tick", tick, 1'b0);
    #2;
    rst_n = 1'b1;
    tr = cyc;
    push_tick(tr + 21);
    push_tick(tr + 41);
    wait_edge(tr + 45);
    check("post_rst_level", level, 4'd0);
    check("q_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pace_scheduler.md
Name: pace_scheduler

Overview:
Parametrised game-tick generator, the successor to the fixed 125 ms pacer. It emits a one-cycle `tick` whose period shortens in fixed steps as the game speeds up, down to a floor. It also supports pause/resume, enable gating and a slow `blink` output derived from ticks. It sits between the top-level clock and the snake movement/scoring logic.

Parameters:
- BASE_PERIOD, 6250000: tick period in clk cycles at level 0 (125 ms at 50 MHz).
- STEP, 390625: cycles removed from the period per speed level.
- MIN_PERIOD, 1562500: floor period; a speed-up is refused if it would go below this.
- CNT_W, 23: cycle-counter width; must satisfy 2^CNT_W > BASE_PERIOD.
- LEVEL_W, 4: speed-level width; level also saturates at 2^LEVEL_W-1.
- BLINK_TICKS, 4: ticks per `blink` toggle.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 0 forces IDLE
- pause_toggle  in  1  one-cycle pulse; toggles RUN/PAUSED
- speed_up  in  1  one-cycle pulse; request next level
- speed_reset  in  1  one-cycle pulse; return to level 0
- tick  out  1  registered one-cycle pace pulse
- level  out  LEVEL_W  current speed level
- paused  out  1  high in PAUSED
- blink  out  1  square wave, toggles every BLINK_TICKS ticks

Behaviour:
- Reset (rst_n low, async): state=IDLE, count=0, period=BASE_PERIOD, level=0, tick=0, paused=0, blink=0, tick_cnt=0.
- Cycle counter
  - No multiplier. A `period` register is adjusted by ±STEP.
- States: IDLE, RUN, PAUSED.
  - IDLE: count and tick_cnt held 0, tick=0. On enable=1 go to RUN; count=0 on that edge.
  - RUN, each edge:
    - if count >= period-1: count<=0, tick<=1, tick_cnt advances.
    - else: count<=count+1, tick<=0.
    - First tick is high in the cycle after the period-th RUN edge. Tick spacing is exactly `period` cycles.
  - pause_toggle in RUN: go to PAUSED, paused<=1, count frozen, tick<=0.
  - pause_toggle in PAUSED: go to RUN, paused<=0, counting resumes from the frozen count. Total RUN cycles between ticks are unchanged.
  - pause_toggle in IDLE: ignored.
  - enable=0 in any state: go to IDLE next edge, count=0, paused=0, tick=0. Level, period and blink are retained.
- Speed control (active in every state):
  - speed_up: if period-STEP >= MIN_PERIOD and level != all-ones, then period-=STEP and level+=1; otherwise ignored (saturate).
  - speed_reset: period=BASE_PERIOD, level=0.
  - Simultaneous speed_up and speed_reset: speed_reset wins.
  - A period change takes effect on the next compare. If count is already >= new period-1, the tick fires on the next RUN edge and count wraps. No tick is lost or doubled.
- Blink:
  - tick_cnt counts ticks modulo BLINK_TICKS. On wrap to 0, blink toggles, in the same edge that sets tick.
  - Frozen in PAUSED. tick_cnt cleared in IDLE; blink holds its value.
- Simultaneous pause_toggle and tick-compare in RUN: the pause wins. No tick, count frozen at its current value (not wrapped). On resume the tick fires on the first RUN edge.
- Reset mid-operation: all registers return immediately to reset values, with no glitch pulse on tick.
- Arithmetic: period and count are CNT_W unsigned. The speed_up check is done as `period >= MIN_PERIOD+STEP` to avoid underflow.

Test Plan (bench params BASE_PERIOD=20, STEP=4, MIN_PERIOD=8, CNT_W=6, LEVEL_W=4, BLINK_TICKS=2):
- Reset release, enable=1 held → tick high 1 cycle at RUN edges 20, 40, 60; level=0; blink toggles at the 2nd and 4th tick.
- speed_up pulsed 4 times while running → level 1,2,3,3 (4th pulse ignored); tick spacing 16, 12, then 8 cycles; never below 8.
- Running, pause_toggle at count=10, hold 50 cycles, pause_toggle again → paused=1 during the hold, no tick, blink frozen; next tick 10 RUN cycles after resume.
- Level 3 (period 8), count=5, speed_reset and speed_up in the same cycle → level=0, period=20; next tick at count 19, not at 7.
- Level 0, count=15, speed_up twice (period 12) → tick on the next edge, then spacing 12.
- enable dropped mid-period, then rst_n pulsed low async mid-PAUSED → IDLE, count 0, tick 0, level retained; after rst_n all outputs are 0 and level=0 immediately, without waiting for a clk edge.
